scaler_readout_arb: RTL

SCALER_READOUT_ARB -- requirements
Module: scaler_readout_arb

---
 rtl/scaler_readout_arb_if.sv | 23 ++
 rtl/scaler_readout_arb.sv | 130 +++++++++++++
 2 files changed

// File: rtl/scaler_readout_arb_if.sv
// Wishbone read port and AXI4-Stream dump port of the scaler readout arbiter.
// The master is the bus/sink side and the slave is the arbiter.
interface scaler_readout_arb_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic [6:0]  wb_adr;
    logic        wb_ack;
    logic [31:0] wb_dat;
    logic [11:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;

    modport master (
        output wb_cyc, wb_stb, wb_adr, m_tready,
        input  wb_ack, wb_dat, m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_adr, m_tready,
        output wb_ack, wb_dat, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/scaler_readout_arb.sv
// Shares one scaler RAM read port between Wishbone reads and an AXI4-Stream bank
// dump. Arbitration is round-robin, and each access takes three cycles.
module scaler_readout_arb #(
    parameter int unsigned NSCALERS = 96,
    parameter int unsigned OVR_BITS = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                done_i,
    input  logic                stream_en_i,
    scaler_readout_arb_if.slave bus,
    output logic [6:0]          scal_adr_o,
    input  logic [11:0]         scal_dat_i,
    output logic                busy_o,
    output logic [OVR_BITS-1:0] ovr_cnt_o
);

    typedef enum logic [2:0] {
        StIdle,
        StIssueWb,
        StDataWb,
        StIssueSt,
        StDataSt
    } state_e;

    localparam logic [6:0] LastAdr = 7'(NSCALERS - 1);

    state_e              r_state;
    logic [6:0]          r_scal_adr;
    logic                r_ack;
    logic [31:0]         r_dat;
    logic [11:0]         r_tdata;
    logic                r_tvalid;
    logic                r_tlast;
    logic                r_st_pend;
    logic [6:0]          r_st_adr;
    logic                r_last_st;
    logic [OVR_BITS-1:0] r_ovr;

    logic w_wb_req;
    logic w_st_req;
    logic w_grant_wb;
    logic w_grant_st;
    logic w_wb_in_range;

    // The ack cycle masks the request that the master has not yet dropped.
    assign w_wb_req      = bus.wb_cyc && bus.wb_stb && !r_ack;
    assign w_st_req      = r_st_pend && (!r_tvalid || bus.m_tready);
    assign w_grant_wb    = w_wb_req && (!w_st_req || r_last_st);
    assign w_grant_st    = w_st_req && !w_grant_wb;
    assign w_wb_in_range = {25'd0, r_scal_adr} < NSCALERS;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state    <= StIdle;
            r_scal_adr <= '0;
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_st_pend  <= 1'b0;
            r_st_adr   <= '0;
            r_last_st  <= 1'b1;
            r_ovr      <= '0;
        end else begin
            r_ack <= 1'b0;
            if (r_tvalid && bus.m_tready) begin
                r_tvalid <= 1'b0;
            end

            if (done_i && stream_en_i) begin
                if (r_st_pend) begin
                    if (r_ovr != '1) begin
                        r_ovr <= r_ovr + OVR_BITS'(1);
                    end
                end else begin
                    r_st_pend <= 1'b1;
                    r_st_adr  <= '0;
                end
            end

            unique case (r_state)
                StIdle: begin
                    if (w_grant_wb) begin
                        r_state    <= StIssueWb;
                        r_scal_adr <= bus.wb_adr;
                        r_last_st  <= 1'b0;
                    end else if (w_grant_st) begin
                        r_state    <= StIssueSt;
                        r_scal_adr <= r_st_adr;
                        r_last_st  <= 1'b1;
                    end
                end
                StIssueWb: r_state <= StDataWb;
                StDataWb: begin
                    r_state <= StIdle;
                    // An abandoned cycle still frees the port, just without an ack.
                    if (bus.wb_cyc) begin
                        r_ack <= 1'b1;
                        r_dat <= w_wb_in_range ? {20'd0, scal_dat_i} : 32'd0;
                    end
                end
                StIssueSt: r_state <= StDataSt;
                StDataSt: begin
                    r_state  <= StIdle;
                    r_tdata  <= scal_dat_i;
                    r_tvalid <= 1'b1;
                    r_tlast  <= (r_st_adr == LastAdr);
                    if (r_st_adr == LastAdr) begin
                        r_st_pend <= 1'b0;
                    end else begin
                        r_st_adr <= r_st_adr + 7'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.wb_ack   = r_ack;
    assign bus.wb_dat   = r_dat;
    assign bus.m_tdata  = r_tdata;
    assign bus.m_tvalid = r_tvalid;
    assign bus.m_tlast  = r_tlast;
    assign scal_adr_o   = r_scal_adr;
    assign ovr_cnt_o    = r_ovr;
    assign busy_o       = r_st_pend || (r_tvalid && r_tlast);

endmodule
